// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic MAC array and its edge feeder.
// Latency: n/a (types only). Backpressure: n/a.
package systolic_pkg;

    localparam int DEF_ROWS           = 4;
    localparam int DEF_COLS           = 4;
    localparam int DEF_IFMAP_BITWIDTH = 16;
    localparam int DEF_W_BITWIDTH     = 8;
    localparam int DEF_CNT_BITWIDTH   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth {en, data} shift chain feeding one PE row; data is zeroed when en is low.
// Latency: DEPTH cycles. Backpressure: none, shifts every cycle.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_en,
    output logic [WIDTH-1:0] out_dat
);

    logic [DEPTH-1:0] en_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            en_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            en_q[0]  <= in_en;
            dat_q[0] <= in_en ? in_dat : '0;
            for (int i = 1; i < DEPTH; i++) begin
                en_q[i]  <= en_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_en  = en_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/array_edge_feeder.sv
// Sequences one tile into the PE grid edges: weight preload (FEEDER_WLOAD_EN), skewed ifmap stream, drain.
// Latency: weight beat +1 cycle, ifmap row r +1+r cycles. Backpressure: ready is a pure state decode, never depends on valid.
module array_edge_feeder
    import systolic_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int COLS           = DEF_COLS,
    parameter int IFMAP_BITWIDTH = DEF_IFMAP_BITWIDTH,
    parameter int W_BITWIDTH     = DEF_W_BITWIDTH,
    parameter int CNT_BITWIDTH   = DEF_CNT_BITWIDTH
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [CNT_BITWIDTH-1:0]        num_vec,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [COLS*W_BITWIDTH-1:0]     w_data,
    input  logic                           i_valid,
    output logic                           i_ready,
    input  logic [ROWS*IFMAP_BITWIDTH-1:0] i_data,
    output logic [COLS-1:0]                W_en,
    output logic [COLS*W_BITWIDTH-1:0]     W_in,
    output logic [ROWS-1:0]                I_en,
    output logic [ROWS*IFMAP_BITWIDTH-1:0] I_in,
    output logic                           busy,
    output logic                           done
);

    localparam int BCW = $clog2(ROWS) + 1;

    feeder_state_t           state_q, state_d;
    logic [CNT_BITWIDTH-1:0] num_lat;
    logic [CNT_BITWIDTH-1:0] vec_cnt;
    logic [BCW-1:0]          ph_cnt;
    logic                    ph_last;
    logic                    w_acc;
    logic                    i_acc;

    // ph_cnt counts weight beats in LOAD_W and idle cycles in DRAIN
    assign ph_last = (ph_cnt == BCW'(ROWS - 1));
    assign i_acc   = i_valid && i_ready;

`ifdef FEEDER_WLOAD_EN
    assign w_ready = (state_q == LOAD_W);
    assign w_acc   = w_valid && w_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            W_en <= '0;
            W_in <= '0;
        end else begin
            W_en <= {COLS{w_acc}};
            W_in <= w_acc ? w_data : '0;
        end
    end
`else
    logic unused_w;

    assign w_ready  = 1'b0;
    assign w_acc    = 1'b0;
    assign W_en     = '0;
    assign W_in     = '0;
    assign unused_w = ^{w_valid, w_data};
`endif

    assign i_ready = (state_q == STREAM) && (vec_cnt < num_lat);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef FEEDER_WLOAD_EN
                    state_d = LOAD_W;
`else
                    state_d = (num_vec == '0) ? DRAIN : STREAM;
`endif
                end
            end
            LOAD_W: begin
                if (w_acc && ph_last) begin
                    state_d = (num_lat == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (vec_cnt == num_lat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ph_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            num_lat <= '0;
            vec_cnt <= '0;
            ph_cnt  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    vec_cnt <= '0;
                    ph_cnt  <= '0;
                    if (start) begin
                        num_lat <= num_vec;
                    end
                end
                LOAD_W: begin
                    if (w_acc) begin
                        ph_cnt <= ph_last ? '0 : ph_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (i_acc) begin
                        vec_cnt <= vec_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    ph_cnt <= ph_last ? '0 : ph_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Every row sees the same accept/bubble pattern; only the depth differs, giving the diagonal skew
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (IFMAP_BITWIDTH)
        ) u_dl (
            .clk     (clk),
            .rstn    (rstn),
            .in_en   (i_acc),
            .in_dat  (i_data[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH]),
            .out_en  (I_en[r]),
            .out_dat (I_in[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH])
        );
    end

endmodule
